vga_timing_rx: RTL and testbench

//  Receive-side counterpart of the on-chip VGA/HDMI timing generator. Samples a

---
 rtl/vga_timing_rx.sv | 220 ++++++++++++++++++++++
 tb/tb_vga_timing_rx.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_rx.sv
// vga_timing_rx: recovers pixel coordinates and line/frame geometry from a
// parallel hs/vs/de/rgb stream and reports lock to a stable video format.
module vga_timing_rx #(
  parameter logic HS_POL = 1'b1,
  parameter logic VS_POL = 1'b1,
  parameter int   CW     = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          hs,
  input  logic          vs,
  input  logic          de,
  input  logic [7:0]    rgb_r,
  input  logic [7:0]    rgb_g,
  input  logic [7:0]    rgb_b,
  output logic          pix_valid,
  output logic [CW-1:0] pix_x,
  output logic [CW-1:0] pix_y,
  output logic [7:0]    pix_r,
  output logic [7:0]    pix_g,
  output logic [7:0]    pix_b,
  output logic          frame_start,
  output logic [CW-1:0] h_total,
  output logic [CW-1:0] h_active,
  output logic [CW-1:0] v_total,
  output logic [CW-1:0] v_active,
  output logic          locked,
  output logic          err
);

  localparam logic [1:0] ST_SEARCH  = 2'd0;
  localparam logic [1:0] ST_MEASURE = 2'd1;
  localparam logic [1:0] ST_CHECK   = 2'd2;
  localparam logic [1:0] ST_LOCKED  = 2'd3;

  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_PRE  = CNT_MAX - CNT_ONE;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    if (v == CNT_MAX) begin
      return CNT_MAX;
    end else begin
      return v + CNT_ONE;
    end
  endfunction

  logic            hs_prev_q, vs_prev_q, de_prev_q;
  logic [CW-1:0]   hc_q, hc_d, rc_q, rc_d, vc_q, vc_d, ac_q, ac_d;
  logic [1:0]      state_q, state_d;
  logic [4*CW-1:0] snap_q, snap_d, meas_d;
  logic            pix_valid_q, pix_valid_d;
  logic [CW-1:0]   pix_x_q, pix_x_d, pix_y_q, pix_y_d;
  logic [7:0]      pix_r_q, pix_r_d, pix_g_q, pix_g_d, pix_b_q, pix_b_d;
  logic            frame_start_q, frame_start_d;
  logic [CW-1:0]   h_total_q, h_total_d, h_active_q, h_active_d;
  logic [CW-1:0]   v_total_q, v_total_d, v_active_q, v_active_d;
  logic            locked_q, locked_d, err_q, err_d;
  logic            hs_lead, vs_lead, de_fall, sat_hit, lock_err;
  logic [CW-1:0]   vc_line, ac_line;

  // Edge detection, counters, measurements and lock FSM.
  always_comb begin
    hs_lead = (hs == HS_POL) && (hs_prev_q != HS_POL);
    vs_lead = (vs == VS_POL) && (vs_prev_q != VS_POL);
    de_fall = de_prev_q && !de;

    h_total_d = hs_lead ? sat_inc(hc_q) : h_total_q;
    hc_d      = hs_lead ? CNT_ZERO : sat_inc(hc_q);

    h_active_d = h_active_q;
    if (de) begin
      rc_d = sat_inc(rc_q);
    end else if (de_fall) begin
      rc_d       = CNT_ZERO;
      h_active_d = rc_q;
    end else begin
      rc_d = rc_q;
    end

    // The line closing at a vs edge belongs to the frame being measured.
    vc_line = hs_lead ? sat_inc(vc_q) : vc_q;
    ac_line = de_fall ? sat_inc(ac_q) : ac_q;
    if (vs_lead) begin
      v_total_d  = vc_line;
      v_active_d = ac_line;
      vc_d       = CNT_ZERO;
      ac_d       = CNT_ZERO;
    end else begin
      v_total_d  = v_total_q;
      v_active_d = v_active_q;
      vc_d       = vc_line;
      ac_d       = ac_line;
    end

    sat_hit = (!hs_lead && (hc_q == CNT_PRE)) ||
              (de && (rc_q == CNT_PRE)) ||
              (hs_lead && !vs_lead && (vc_q == CNT_PRE)) ||
              (de_fall && !vs_lead && (ac_q == CNT_PRE));

    pix_valid_d = de;
    pix_x_d     = de ? rc_q : CNT_ZERO;
    pix_y_d     = de ? ac_d : CNT_ZERO;
    pix_r_d     = de ? rgb_r : 8'd0;
    pix_g_d     = de ? rgb_g : 8'd0;
    pix_b_d     = de ? rgb_b : 8'd0;

    meas_d   = {h_total_d, h_active_d, v_total_d, v_active_d};
    state_d  = state_q;
    snap_d   = snap_q;
    lock_err = 1'b0;
    if (vs_lead) begin
      case (state_q)
        ST_SEARCH: begin
          state_d = ST_MEASURE;
        end
        ST_MEASURE: begin
          snap_d  = meas_d;
          state_d = ST_CHECK;
        end
        ST_CHECK: begin
          if (meas_d == snap_q) begin
            state_d = ST_LOCKED;
          end else begin
            snap_d = meas_d;
          end
        end
        ST_LOCKED: begin
          if (meas_d != snap_q) begin
            lock_err = 1'b1;
            state_d  = ST_MEASURE;
          end else begin
            state_d = ST_LOCKED;
          end
        end
        default: begin
          state_d = ST_SEARCH;
        end
      endcase
    end else begin
      state_d = state_q;
    end
    if (sat_hit) begin
      state_d = ST_SEARCH;
    end else begin
      state_d = state_d;
    end

    frame_start_d = vs_lead;
    locked_d      = (state_d == ST_LOCKED);
    err_d         = sat_hit || lock_err;
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hs_prev_q     <= ~HS_POL;
      vs_prev_q     <= ~VS_POL;
      de_prev_q     <= 1'b0;
      hc_q          <= CNT_ZERO;
      rc_q          <= CNT_ZERO;
      vc_q          <= CNT_ZERO;
      ac_q          <= CNT_ZERO;
      state_q       <= ST_SEARCH;
      snap_q        <= {(4*CW){1'b0}};
      pix_valid_q   <= 1'b0;
      pix_x_q       <= CNT_ZERO;
      pix_y_q       <= CNT_ZERO;
      pix_r_q       <= 8'd0;
      pix_g_q       <= 8'd0;
      pix_b_q       <= 8'd0;
      frame_start_q <= 1'b0;
      h_total_q     <= CNT_ZERO;
      h_active_q    <= CNT_ZERO;
      v_total_q     <= CNT_ZERO;
      v_active_q    <= CNT_ZERO;
      locked_q      <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      hs_prev_q     <= hs;
      vs_prev_q     <= vs;
      de_prev_q     <= de;
      hc_q          <= hc_d;
      rc_q          <= rc_d;
      vc_q          <= vc_d;
      ac_q          <= ac_d;
      state_q       <= state_d;
      snap_q        <= snap_d;
      pix_valid_q   <= pix_valid_d;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      pix_r_q       <= pix_r_d;
      pix_g_q       <= pix_g_d;
      pix_b_q       <= pix_b_d;
      frame_start_q <= frame_start_d;
      h_total_q     <= h_total_d;
      h_active_q    <= h_active_d;
      v_total_q     <= v_total_d;
      v_active_q    <= v_active_d;
      locked_q      <= locked_d;
      err_q         <= err_d;
    end
  end

  assign pix_valid   = pix_valid_q;
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign pix_r       = pix_r_q;
  assign pix_g       = pix_g_q;
  assign pix_b       = pix_b_q;
  assign frame_start = frame_start_q;
  assign h_total     = h_total_q;
  assign h_active    = h_active_q;
  assign v_total     = v_total_q;
  assign v_active    = v_active_q;
  assign locked      = locked_q;
  assign err         = err_q;

endmodule

// File: tb/tb_vga_timing_rx.sv
// tb_vga_timing_rx: drives positive- and negative-polarity receivers with the same
// randomized video stream and checks both against a timestamp/event-count model.
module tb_vga_timing_rx;
  localparam int MAXV = 4095;

  typedef struct {
    int ha; int hf; int hsy; int hb;
    int va; int vf; int vsy; int vb;
  } fmt_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, hs_a, vs_a, de;
  logic [7:0] rgb_r, rgb_g, rgb_b;
  logic       hs_n, vs_n;
  assign hs_n = ~hs_a;
  assign vs_n = ~vs_a;

  logic        p_pv, p_fs, p_lk, p_er, n_pv, n_fs, n_lk, n_er;
  logic [11:0] p_px, p_py, p_ht, p_ha, p_vt, p_va, n_px, n_py, n_ht, n_ha, n_vt, n_va;
  logic [7:0]  p_pr, p_pg, p_pb, n_pr, n_pg, n_pb;

  vga_timing_rx #(.HS_POL(1'b1), .VS_POL(1'b1), .CW(12)) dut_p (
    .clk(clk), .rst_n(rst_n), .hs(hs_a), .vs(vs_a), .de(de),
    .rgb_r(rgb_r), .rgb_g(rgb_g), .rgb_b(rgb_b),
    .pix_valid(p_pv), .pix_x(p_px), .pix_y(p_py),
    .pix_r(p_pr), .pix_g(p_pg), .pix_b(p_pb), .frame_start(p_fs),
    .h_total(p_ht), .h_active(p_ha), .v_total(p_vt), .v_active(p_va),
    .locked(p_lk), .err(p_er));

  vga_timing_rx #(.HS_POL(1'b0), .VS_POL(1'b0), .CW(12)) dut_n (
    .clk(clk), .rst_n(rst_n), .hs(hs_n), .vs(vs_n), .de(de),
    .rgb_r(rgb_r), .rgb_g(rgb_g), .rgb_b(rgb_b),
    .pix_valid(n_pv), .pix_x(n_px), .pix_y(n_py),
    .pix_r(n_pr), .pix_g(n_pg), .pix_b(n_pb), .frame_start(n_fs),
    .h_total(n_ht), .h_active(n_ha), .v_total(n_vt), .v_active(n_va),
    .locked(n_lk), .err(n_er));

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;
  int errs_p  = 0;

  // Model: expected outputs after the next edge, and abstract history.
  int e_valid, e_x, e_y, e_r, e_g, e_b, e_fs, e_ht, e_ha, e_vt, e_va, e_locked, e_err;
  int t = 0;
  int hs_ref, run_start, lines, act;
  bit phs, pvs, pde;
  bit synced, have_ref, m_locked;
  int ref_m [4];

  function automatic int sat(input int v);
    return (v > MAXV) ? MAXV : v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, a, e, $time);
    end
  endtask

  task automatic model_step();
    bit hl, vl, df, sat_e, lock_e;
    int meas [4];
    if (!rst_n) begin
      {e_valid, e_x, e_y, e_r, e_g, e_b, e_fs} = '0;
      {e_ht, e_ha, e_vt, e_va, e_locked, e_err} = '0;
      phs = 1'b0; pvs = 1'b0; pde = 1'b0;
      hs_ref = t; run_start = t; lines = 0; act = 0;
      synced = 1'b0; have_ref = 1'b0; m_locked = 1'b0;
    end else begin
      hl = hs_a && !phs;
      vl = vs_a && !pvs;
      df = pde && !de;
      sat_e = 1'b0;
      lock_e = 1'b0;
      if (de && !pde) run_start = t;
      if (de && (t - run_start + 1 == MAXV)) sat_e = 1'b1;
      if (df) e_ha = sat(t - run_start);
      if (hl) begin
        e_ht = sat(t - hs_ref);
        hs_ref = t;
      end else if (t - hs_ref == MAXV) begin
        sat_e = 1'b1;
      end
      if (hl) lines++;
      if (df) act++;
      if (vl) begin
        e_vt = sat(lines);
        e_va = sat(act);
        lines = 0;
        act = 0;
        meas = '{e_ht, e_ha, e_vt, e_va};
        if (!synced) synced = 1'b1;
        else if (!have_ref) begin
          ref_m = meas;
          have_ref = 1'b1;
        end else if (meas == ref_m) m_locked = 1'b1;
        else if (m_locked) begin
          lock_e = 1'b1;
          m_locked = 1'b0;
          have_ref = 1'b0;
        end else ref_m = meas;
      end else begin
        if (hl && lines == MAXV) sat_e = 1'b1;
        if (df && act == MAXV) sat_e = 1'b1;
      end
      if (sat_e) begin
        synced = 1'b0; have_ref = 1'b0; m_locked = 1'b0;
      end
      e_valid = de;
      e_x = de ? sat(t - run_start) : 0;
      e_y = de ? sat(act) : 0;
      e_r = de ? rgb_r : 0;
      e_g = de ? rgb_g : 0;
      e_b = de ? rgb_b : 0;
      e_fs = vl;
      e_locked = m_locked;
      e_err = sat_e || lock_e;
      phs = hs_a; pvs = vs_a; pde = de;
    end
    t++;
  endtask

  task automatic drive(input logic rst_i, input logic hs_i, input logic vs_i, input logic de_i);
    rst_n = rst_i; hs_a = hs_i; vs_a = vs_i; de = de_i;
    rgb_r = 8'($urandom); rgb_g = 8'($urandom); rgb_b = 8'($urandom);
    model_step();
  endtask

  task automatic cyc(input logic rst_i, input logic hs_i, input logic vs_i, input logic de_i);
    @(negedge clk);
    drive(rst_i, hs_i, vs_i, de_i);
  endtask

  task automatic cmp_inst(input string tag, input logic pv, input logic [11:0] px, input logic [11:0] py,
                          input logic [7:0] pr, input logic [7:0] pg, input logic [7:0] pb,
                          input logic fs, input logic [11:0] ht, input logic [11:0] ha,
                          input logic [11:0] vt, input logic [11:0] va, input logic lk, input logic er);
    chk({tag, ".pix_valid"}, pv, e_valid);
    chk({tag, ".pix_x"}, px, e_x);
    chk({tag, ".pix_y"}, py, e_y);
    chk({tag, ".pix_rgb"}, {pr, pg, pb}, (e_r << 16) | (e_g << 8) | e_b);
    chk({tag, ".frame_start"}, fs, e_fs);
    chk({tag, ".h_total"}, ht, e_ht);
    chk({tag, ".h_active"}, ha, e_ha);
    chk({tag, ".v_total"}, vt, e_vt);
    chk({tag, ".v_active"}, va, e_va);
    chk({tag, ".locked"}, lk, e_locked);
    chk({tag, ".err"}, er, e_err);
  endtask

  // Per-cycle comparison of both receivers against the model.
  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      cmp_inst("pos", p_pv, p_px, p_py, p_pr, p_pg, p_pb, p_fs, p_ht, p_ha, p_vt, p_va, p_lk, p_er);
      cmp_inst("neg", n_pv, n_px, n_py, n_pr, n_pg, n_pb, n_fs, n_ht, n_ha, n_vt, n_va, n_lk, n_er);
      if (p_er === 1'b1) errs_p++;
    end
  end

  task automatic frame(input fmt_t f, input int ext_line, input int rst_at, input bit pin);
    int ht, vt, hde0, vde0, len, idx;
    logic hs_i, vs_i, de_i, rst_i;
    ht = f.hsy + f.hb + f.ha + f.hf;
    vt = f.vsy + f.vb + f.va + f.vf;
    hde0 = f.hsy + f.hb;
    vde0 = f.vsy + f.vb;
    idx = 0;
    for (int v = 0; v < vt; v++) begin
      len = ht + ((v == ext_line) ? 1 : 0);
      for (int h = 0; h < len; h++) begin
        hs_i = (h < f.hsy);
        vs_i = (v < f.vsy);
        de_i = (h >= hde0) && (h < hde0 + f.ha) && (v >= vde0) && (v < vde0 + f.va);
        rst_i = (idx != rst_at);
        @(negedge clk);
        if (pin && v == vde0 && h == hde0 + 1) begin
          chk("first_pix.valid", p_pv, 1);
          chk("first_pix.x", p_px, 0);
          chk("first_pix.y", p_py, 0);
        end
        if (pin && v == vde0 + f.va - 1 && h == hde0 + f.ha) begin
          chk("last_pix.x", p_px, 15);
          chk("last_pix.y", p_py, 5);
        end
        if (rst_at >= 0 && idx == rst_at + 1) begin
          chk("midreset.pix_valid", n_pv | p_pv, 0);
          chk("midreset.h_total", p_ht | n_ht, 0);
          chk("midreset.v_total", p_vt, 0);
          chk("midreset.locked", p_lk | n_lk, 0);
          chk("midreset.err", p_er, 0);
        end
        drive(rst_i, hs_i, vs_i, de_i);
        idx++;
      end
    end
  endtask

  fmt_t f0, fr;
  int   e0, ext;

  initial begin
    f0 = '{ha: 16, hf: 2, hsy: 3, hb: 4, va: 6, vf: 1, vsy: 2, vb: 2};
    rst_n = 1'b0; hs_a = 1'b0; vs_a = 1'b0; de = 1'b0;
    rgb_r = 8'd0; rgb_g = 8'd0; rgb_b = 8'd0;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk_en = 1'b1;
    repeat (2) cyc(1'b0, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    chk("reset.locked", p_lk, 0);
    chk("reset.h_total", p_ht, 0);
    chk("reset.pix_valid", p_pv, 0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);

    // Three clean frames lock; values pinned by hand.
    frame(f0, -1, -1, 1'b1);
    frame(f0, -1, -1, 1'b0);
    frame(f0, -1, -1, 1'b0);
    @(negedge clk);
    chk("lock.locked", p_lk, 1);
    chk("lock.neg_locked", n_lk, 1);
    chk("lock.h_total", p_ht, 25);
    chk("lock.h_active", p_ha, 16);
    chk("lock.v_total", n_vt, 11);
    chk("lock.v_active", n_va, 6);
    chk("model.h_total", e_ht, 25);
    chk("model.locked", e_locked, 1);
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    frame(f0, -1, -1, 1'b0);

    // Longer last line while locked: one err, relock two frames later.
    e0 = errs_p;
    frame(f0, 10, -1, 1'b0);
    frame(f0, -1, -1, 1'b0);
    chk("lenerr.err_pulses", errs_p - e0, 1);
    chk("lenerr.locked", p_lk, 0);
    frame(f0, -1, -1, 1'b0);
    chk("lenerr.still_unlocked", p_lk, 0);
    frame(f0, -1, -1, 1'b0);
    chk("lenerr.relocked", p_lk, 1);

    for (int k = 0; k < 8; k++) begin
      fr.ha = $urandom_range(4, 24); fr.hf = $urandom_range(1, 4);
      fr.hsy = $urandom_range(2, 5); fr.hb = $urandom_range(1, 4);
      fr.va = $urandom_range(3, 12); fr.vf = $urandom_range(1, 3);
      fr.vsy = $urandom_range(1, 3); fr.vb = $urandom_range(1, 3);
      for (int j = 0; j < 4; j++) begin
        ext = ($urandom_range(0, 1) == 1) ? $urandom_range(0, fr.vsy + fr.vb + fr.va + fr.vf - 2) : -1;
        frame(fr, ext, -1, 1'b0);
      end
    end

    for (int j = 0; j < 4; j++) frame(f0, -1, -1, 1'b0);
    chk("presat.locked", p_lk, 1);

    // Lines without vs saturate vc; then a long de run saturates hc and rc.
    e0 = errs_p;
    for (int i = 0; i < 16400; i++) cyc(1'b1, (i % 4) == 0, 1'b0, 1'b0);
    @(negedge clk);
    chk("vsat.err_pulses", errs_p - e0, 1);
    chk("vsat.locked", p_lk, 0);
    chk("vsat.neg_locked", n_lk, 0);
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    e0 = errs_p;
    for (int i = 0; i < 4200; i++) cyc(1'b1, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk("hsat.err_pulses", errs_p - e0, 2);
    chk("hsat.h_total", p_ht, 4);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    for (int j = 0; j < 3; j++) frame(f0, -1, -1, 1'b0);
    chk("postsat.locked", p_lk, 1);

    // One-cycle reset in the middle of an active line.
    frame(f0, -1, 112, 1'b0);
    for (int j = 0; j < 3; j++) frame(f0, -1, -1, 1'b0);
    chk("postrst.locked", p_lk, 1);
    chk("postrst.h_active", n_ha, 16);

    repeat (4) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
